// File: rtl/nd_2to1_pkg.sv
// nd_2to1 shared definitions: global size macros, output FSM states.
// Feature macro NS_ND_2TO1_FAIR_RR_EN selects round-robin arbitration.
`ifndef NS_2to1_FSZ
`define NS_2to1_FSZ 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_ON
`define NS_ON 1'b1
`endif
`ifndef NS_OFF
`define NS_OFF 1'b0
`endif

package nd_2to1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } snd_state_t;

    function automatic int msg_width(input int asz, input int dsz, input int rsz);
        return 2 * asz + dsz + rsz;
    endfunction

endpackage

// File: rtl/nd_msg_fifo.sv
// Per-input message FIFO, power-of-two depth, pointers wrap naturally.
// Packed message layout is {src, dst, dat, red}.
`ifndef NS_2to1_FSZ
`define NS_2to1_FSZ 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_msg_fifo
    import nd_2to1_pkg::*;
#(
    parameter int FSZ = `NS_2to1_FSZ,
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE,
    localparam int MW = msg_width(ASZ, DSZ, RSZ)
) (
    input  logic          i_clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [MW-1:0] din,
    output logic [MW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(FSZ);
    localparam logic [PW:0] FULL_CNT = FSZ[PW:0];

    logic [MW-1:0] mem [FSZ];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic          wr;
    logic          rd;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign dout  = mem[head];

    always_ff @(posedge i_clk) begin
        if (wr) mem[tail] <= din;
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr) tail <= tail + 1'b1;
            if (rd) head <= head + 1'b1;
            unique case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nd_2to1.sv
// Two-input to one-output 4-phase message merger with per-input FIFOs.
// Define NS_ND_2TO1_FAIR_RR_EN for round-robin, otherwise input 0 has priority.
`ifndef NS_2to1_FSZ
`define NS_2to1_FSZ 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_ON
`define NS_ON 1'b1
`endif
`ifndef NS_OFF
`define NS_OFF 1'b0
`endif

module nd_2to1
    import nd_2to1_pkg::*;
#(
    parameter int FSZ = `NS_2to1_FSZ,
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE,
    localparam int MW = msg_width(ASZ, DSZ, RSZ)
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv1_req,
    output logic           rcv1_ack,
    input  logic [ASZ-1:0] rcv1_src,
    input  logic [ASZ-1:0] rcv1_dst,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic [RSZ-1:0] rcv1_red,
    output logic           snd0_req,
    input  logic           snd0_ack,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red
);

    logic [MW-1:0] din0;
    logic [MW-1:0] din1;
    logic [MW-1:0] dout0;
    logic [MW-1:0] dout1;
    logic [MW-1:0] out_q;
    logic          full0;
    logic          full1;
    logic          empty0;
    logic          empty1;
    logic          push0;
    logic          push1;
    logic          pop0;
    logic          pop1;
    logic          pop_any;
    logic          grant1;
    snd_state_t    state;
    snd_state_t    state_nx;

    // First edge after reset release is the init cycle.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) ready <= `NS_OFF;
        else        ready <= `NS_ON;
    end

    assign din0  = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
    assign din1  = {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red};
    assign push0 = ready && rcv0_req && !rcv0_ack && !full0;
    assign push1 = ready && rcv1_req && !rcv1_ack && !full1;

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            rcv0_ack <= `NS_OFF;
            rcv1_ack <= `NS_OFF;
        end else begin
            if (push0)                      rcv0_ack <= `NS_ON;
            else if (rcv0_ack && !rcv0_req) rcv0_ack <= `NS_OFF;
            if (push1)                      rcv1_ack <= `NS_ON;
            else if (rcv1_ack && !rcv1_req) rcv1_ack <= `NS_OFF;
        end
    end

    nd_msg_fifo #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_fifo0 (
        .i_clk (i_clk),
        .reset (reset),
        .push  (push0),
        .pop   (pop0),
        .din   (din0),
        .dout  (dout0),
        .full  (full0),
        .empty (empty0)
    );

    nd_msg_fifo #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_fifo1 (
        .i_clk (i_clk),
        .reset (reset),
        .push  (push1),
        .pop   (pop1),
        .din   (din1),
        .dout  (dout1),
        .full  (full1),
        .empty (empty1)
    );

`ifdef NS_ND_2TO1_FAIR_RR_EN
    logic rr_fav1;

    // Favour the input that lost (or was absent from) the last grant.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset)       rr_fav1 <= `NS_OFF;
        else if (pop_any) rr_fav1 <= !grant1;
    end

    assign grant1 = !empty1 && (empty0 || rr_fav1);
`else
    assign grant1 = empty0 && !empty1;
`endif

    assign pop0 = pop_any && !grant1;
    assign pop1 = pop_any && grant1;

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:     if (ready && (!empty0 || !empty1)) state_nx = ST_SEND;
            ST_SEND:     if (snd0_ack) state_nx = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!snd0_ack) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        snd0_req = `NS_OFF;
        pop_any  = `NS_OFF;
        unique case (state)
            ST_IDLE: pop_any  = ready && (!empty0 || !empty1);
            ST_SEND: snd0_req = `NS_ON;
            default: ;
        endcase
    end

    // Output fields only load in IDLE, so they hold through the handshake.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset)       out_q <= '0;
        else if (pop_any) out_q <= grant1 ? dout1 : dout0;
    end

    assign {snd0_src, snd0_dst, snd0_dat, snd0_red} = out_q;

endmodule
